comm_slave: RTL and testbench
=============================

Name: comm_slave

Overview:
- Copter-side endpoint of the wireless command link; the counterpart to the ground-side CommMaster.
- Sits between the copter's UART byte receiver/transmitter and the command-processing logic.
- Receive path: assembles 3-byte frames (cmd, data_hi, data_lo) into an opcode plus 16-bit data and flags them ready.
- Transmit path: sends the 1-byte response (battery reading, positive ack 8'hA5, etc.) back through the UART transmitter with a simple handshake.

Parameters:
- TIMEOUT_CYC, 65536: inter-byte timeout in clk cycles; a partial frame older than this is discarded.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_rdy  in  1  one-cycle pulse, a received byte is valid on rx_data
- rx_data  in  8  received byte from UART receiver
- cmd_rdy  out  1  complete frame available on cmd/data
- cmd  out  8  opcode of last complete frame
- data  out  16  data of last complete frame, {hi,lo}
- clr_cmd_rdy  in  1  consumer knocks down cmd_rdy
- frm_err  out  1  one-cycle pulse, partial frame dropped on timeout
- resp  in  8  response byte to send
- send_resp  in  1  one-cycle request to send resp
- tx_data  out  8  byte to UART transmitter
- trmt  out  1  one-cycle start pulse to UART transmitter
- tx_done  in  1  one-cycle pulse, UART transmitter finished the byte
- tx_busy  out  1  response transmission in progress
- resp_sent  out  1  one-cycle pulse, response fully sent

Behaviour:
- Reset values: cmd_rdy=0, cmd=8'h00, data=16'h0000, frm_err=0, tx_data=8'h00, trmt=0, tx_busy=0, resp_sent=0; both FSMs in IDLE; timeout counter=0.
- RX FSM states: IDLE, WAIT_HI, WAIT_LO.
  - IDLE + rx_rdy: store byte in cmd shadow register; go to WAIT_HI.
  - WAIT_HI + rx_rdy: store byte in hi shadow register; go to WAIT_LO.
  - WAIT_LO + rx_rdy: cmd <= cmd shadow, data <= {hi shadow, rx_data}, cmd_rdy <= 1 in the same edge; return to IDLE. Latency: cmd_rdy visible the cycle after the third rx_rdy.
- cmd and data change only on frame completion, so they stay stable while cmd_rdy=1 and until the next completed frame.
- cmd_rdy clear conditions:
  - cleared on clr_cmd_rdy;
  - also cleared on rx_rdy in IDLE (start of next frame);
  - if set and clear occur in the same cycle, set wins.
- Timeout counter (17 bits):
  - cleared on every rx_rdy and whenever the FSM is in IDLE;
  - increments each cycle in WAIT_HI or WAIT_LO;
  - on reaching TIMEOUT_CYC-1 without rx_rdy: FSM goes to IDLE, frm_err pulses 1 cycle, shadow registers are don't-care, cmd_rdy/cmd/data are unchanged;
  - rx_rdy in the same cycle as expiry: the byte wins, no error.
- TX FSM states: IDLE, BUSY.
  - IDLE + send_resp: tx_data <= resp, trmt pulses 1 cycle (next cycle), tx_busy <= 1; go to BUSY.
  - BUSY + tx_done: tx_busy <= 0, resp_sent pulses 1 cycle; go to IDLE.
  - send_resp while BUSY is ignored; the byte is not queued.
  - send_resp in the same cycle as tx_done is also ignored; the requester must wait for resp_sent.
- RX and TX paths are fully independent; simultaneous rx_rdy and send_resp are both serviced.
- rst mid-frame or mid-transmit: all state returns to reset values next edge; partial bytes are discarded; no frm_err or resp_sent pulse is generated.

Test Plan:
- Frame 8'h02, 8'h00, 8'h3A with 2600 cycles between bytes -> cmd_rdy=1 one cycle after third rx_rdy; cmd=8'h02; data=16'h003A; frm_err never asserts.
- Frame 8'h04, 8'h80, 8'h0A, then pulse clr_cmd_rdy -> data=16'h800A, cmd_rdy falls next edge; second frame 8'h05, 8'h00, 8'hFD with no clear in between -> cmd=8'h05, data=16'h00FD, cmd_rdy falls at first byte and rises after third.
- Send 8'h01, 8'hFF, then idle TIMEOUT_CYC cycles -> one frm_err pulse, cmd_rdy stays 0; then full frame 8'h06, 8'h00, 8'h00 -> cmd=8'h06, data=16'h0000.
- send_resp with resp=8'hA5 -> trmt single pulse, tx_data=8'hA5, tx_busy=1; send_resp with 8'hC0 while busy -> ignored, tx_data stays 8'hA5; tx_done -> resp_sent pulse, tx_busy=0.
- Assert rst after second byte of 8'h03, 8'h00 and during BUSY -> all outputs at reset values; following bytes 8'h00, 8'h3A, 8'h07 are treated as a new frame -> cmd=8'h00, data=16'h3A07.
- Third byte rx_rdy coincident with clr_cmd_rdy while cmd_rdy=1 -> cmd_rdy remains 1 with the new cmd/data.

Source files
------------

// File: rtl/comm_slave.sv
// Copter-side command link endpoint: 3-byte frames in -> cmd/data out; 1-byte responses out via UART handshake.
// Latency: cmd_rdy one cycle after the third byte, trmt one cycle after send_resp; no queueing, send_resp while busy is dropped.
module comm_slave #(
    parameter int TIMEOUT_CYC = 65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        cmd_rdy,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    input  logic        clr_cmd_rdy,
    output logic        frm_err,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic [7:0]  tx_data,
    output logic        trmt,
    input  logic        tx_done,
    output logic        tx_busy,
    output logic        resp_sent
);

    localparam logic [16:0] TO_LAST = 17'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_WAIT_HI, RX_WAIT_LO} rx_state_t;
    typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

    rx_state_t   rx_state_q;
    logic [7:0]  cmd_sh_q;
    logic [7:0]  hi_sh_q;
    logic [7:0]  cmd_q;
    logic [15:0] data_q;
    logic        cmd_rdy_q;
    logic        frm_err_q;
    logic [16:0] to_cnt_q;
    logic        timeout;

    tx_state_t   tx_state_q;
    logic [7:0]  tx_data_q;
    logic        trmt_q;
    logic        tx_busy_q;
    logic        resp_sent_q;

    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign timeout = (rx_state_q != RX_IDLE) && !rx_rdy && (to_cnt_q == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q <= RX_IDLE;
            cmd_sh_q   <= 8'h00;
            hi_sh_q    <= 8'h00;
            cmd_q      <= 8'h00;
            data_q     <= 16'h0000;
            cmd_rdy_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            to_cnt_q   <= 17'd0;
        end else begin
            frm_err_q <= 1'b0;
            // Frame completion below overrides this clear.
            if (clr_cmd_rdy) cmd_rdy_q <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    to_cnt_q <= 17'd0;
                    if (rx_rdy) begin
                        cmd_sh_q   <= rx_data;
                        cmd_rdy_q  <= 1'b0;
                        rx_state_q <= RX_WAIT_HI;
                    end
                end
                RX_WAIT_HI: begin
                    if (rx_rdy) begin
                        hi_sh_q    <= rx_data;
                        to_cnt_q   <= 17'd0;
                        rx_state_q <= RX_WAIT_LO;
                    end else if (timeout) begin
                        frm_err_q  <= 1'b1;
                        to_cnt_q   <= 17'd0;
                        rx_state_q <= RX_IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 17'd1;
                    end
                end
                RX_WAIT_LO: begin
                    if (rx_rdy) begin
                        cmd_q      <= cmd_sh_q;
                        data_q     <= {hi_sh_q, rx_data};
                        cmd_rdy_q  <= 1'b1;
                        to_cnt_q   <= 17'd0;
                        rx_state_q <= RX_IDLE;
                    end else if (timeout) begin
                        frm_err_q  <= 1'b1;
                        to_cnt_q   <= 17'd0;
                        rx_state_q <= RX_IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 17'd1;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q  <= TX_IDLE;
            tx_data_q   <= 8'h00;
            trmt_q      <= 1'b0;
            tx_busy_q   <= 1'b0;
            resp_sent_q <= 1'b0;
        end else begin
            trmt_q      <= 1'b0;
            resp_sent_q <= 1'b0;
            case (tx_state_q)
                TX_IDLE: begin
                    if (send_resp) begin
                        tx_data_q  <= resp;
                        trmt_q     <= 1'b1;
                        tx_busy_q  <= 1'b1;
                        tx_state_q <= TX_BUSY;
                    end
                end
                TX_BUSY: begin
                    if (tx_done) begin
                        tx_busy_q   <= 1'b0;
                        resp_sent_q <= 1'b1;
                        tx_state_q  <= TX_IDLE;
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    assign cmd_rdy   = cmd_rdy_q;
    assign cmd       = cmd_q;
    assign data      = data_q;
    assign frm_err   = frm_err_q;
    assign tx_data   = tx_data_q;
    assign trmt      = trmt_q;
    assign tx_busy   = tx_busy_q;
    assign resp_sent = resp_sent_q;

endmodule

// File: tb/tb_comm_slave.sv
// Bench for comm_slave: directed frame/response scenarios then random traffic against a frame-level model.
module tb_comm_slave;

    localparam int T = 3000;

    logic        clk = 1'b0;
    logic        rst, rx_rdy, clr_cmd_rdy, send_resp, tx_done;
    logic [7:0]  rx_data, resp;
    logic        cmd_rdy, frm_err, trmt, tx_busy, resp_sent;
    logic [7:0]  cmd, tx_data;
    logic [15:0] data;

    comm_slave #(.TIMEOUT_CYC(T)) dut (
        .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data),
        .cmd_rdy(cmd_rdy), .cmd(cmd), .data(data), .clr_cmd_rdy(clr_cmd_rdy),
        .frm_err(frm_err), .resp(resp), .send_resp(send_resp), .tx_data(tx_data),
        .trmt(trmt), .tx_done(tx_done), .tx_busy(tx_busy), .resp_sent(resp_sent)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Pulse counters observed shortly after every rising edge.
    int n_err = 0, n_trmt = 0, n_sent = 0;
    always @(posedge clk) begin
        #1;
        if (frm_err === 1'b1) n_err++;
        if (trmt === 1'b1) n_trmt++;
        if (resp_sent === 1'b1) n_sent++;
    end

    // Reference model: pending frame bytes plus the last delivered frame.
    logic [7:0]  m_q[$];
    logic [7:0]  m_cmd, m_txd;
    logic [15:0] m_data;
    logic        m_rdy, m_busy;
    int          m_err, m_trmt, m_sent;
    int          cyc = 0;
    int          last_t = 0;

    task automatic expire(input int upto);
        if (m_q.size() > 0 && upto - last_t >= T) begin
            m_q.delete();
            m_err++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        expire(cyc);
        chk({tag, ".cmd_rdy"}, 32'(cmd_rdy), 32'(m_rdy));
        chk({tag, ".cmd"}, 32'(cmd), 32'(m_cmd));
        chk({tag, ".data"}, 32'(data), 32'(m_data));
        chk({tag, ".tx_busy"}, 32'(tx_busy), 32'(m_busy));
        chk({tag, ".tx_data"}, 32'(tx_data), 32'(m_txd));
        chk({tag, ".frm_err_cnt"}, 32'(n_err), 32'(m_err));
        chk({tag, ".trmt_cnt"}, 32'(n_trmt), 32'(m_trmt));
        chk({tag, ".sent_cnt"}, 32'(n_sent), 32'(m_sent));
    endtask

    // One clock cycle of stimulus, applied to DUT and model together.
    task automatic step(input logic r, input logic rv, input logic [7:0] rd, input logic cl,
                        input logic sn, input logic [7:0] rs, input logic dn);
        rst = r; rx_rdy = rv; rx_data = rd; clr_cmd_rdy = cl;
        send_resp = sn; resp = rs; tx_done = dn;
        cyc++;
        expire(cyc - 1);
        if (r) begin
            m_q.delete();
            m_cmd = 8'h00; m_data = 16'h0000; m_rdy = 1'b0;
            m_busy = 1'b0; m_txd = 8'h00;
        end else begin
            if (cl) m_rdy = 1'b0;
            if (rv) begin
                if (m_q.size() == 0) m_rdy = 1'b0;
                m_q.push_back(rd);
                last_t = cyc;
                if (m_q.size() == 3) begin
                    m_cmd  = m_q[0];
                    m_data = {m_q[1], m_q[2]};
                    m_rdy  = 1'b1;
                    m_q.delete();
                end
            end
            if (!m_busy) begin
                if (sn) begin m_txd = rs; m_busy = 1'b1; m_trmt++; end
            end else if (dn) begin
                m_busy = 1'b0; m_sent++;
            end
        end
        @(negedge clk);
    endtask

    task automatic rxb(input logic [7:0] b);
        step(1'b0, 1'b1, b, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        m_cmd = 8'h00; m_data = 16'h0000; m_rdy = 1'b0; m_busy = 1'b0; m_txd = 8'h00;
        m_err = 0; m_trmt = 0; m_sent = 0;
        @(negedge clk);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        check_all("reset");
        chk("reset.cmd_rdy_zero", 32'(cmd_rdy), 32'd0);

        // Slow frame, gaps well inside the timeout.
        rxb(8'h02); idle(2599); rxb(8'h00); idle(2599);
        check_all("slow.before_third");
        rxb(8'h3A);
        check_all("slow.done");
        chk("slow.data", 32'(data), 32'h003A);

        // Consumer clear, then back-to-back frame without clear.
        rxb(8'h04); rxb(8'h80); rxb(8'h0A);
        check_all("f04");
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
        check_all("f04.clr");
        rxb(8'h05); rxb(8'h00); rxb(8'hFD);
        check_all("f05");
        rxb(8'h01);
        check_all("start_drops_rdy");

        // Timeout on a partial frame, then a clean frame.
        rxb(8'hFF); idle(T);
        check_all("timeout");
        chk("timeout.one_pulse", 32'(n_err), 32'd1);
        rxb(8'h06); rxb(8'h00); rxb(8'h00);
        check_all("f06");

        // Byte landing exactly on the expiry cycle wins.
        rxb(8'h09); idle(T - 1); rxb(8'h11); idle(T - 1); rxb(8'h22);
        check_all("expiry_edge");

        // Response path.
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0);
        check_all("tx.start");
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hC0, 1'b0);
        check_all("tx.ignored");
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        check_all("tx.done");
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h77, 1'b1);
        check_all("tx.send_with_done");

        // Reset mid-frame and mid-transmit.
        rxb(8'h03); rxb(8'h00);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h3C, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        check_all("midrst");
        rxb(8'h00); rxb(8'h3A); rxb(8'h07);
        check_all("after_rst");
        chk("after_rst.data", 32'(data), 32'h3A07);

        // Set beats clear on the completing byte.
        rxb(8'h10); rxb(8'h20);
        step(1'b0, 1'b1, 8'h30, 1'b1, 1'b0, 8'h00, 1'b0);
        check_all("set_wins");

        // Random traffic.
        for (int i = 0; i < 120; i++) begin
            int op;
            op = int'($urandom_range(0, 15));
            if (op < 8) begin
                step(1'b0, 1'b1, 8'($urandom), ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 3) == 0), 8'($urandom), ($urandom_range(0, 3) == 0));
            end else if (op < 13) begin
                idle(int'($urandom_range(0, 6)));
            end else if (op == 13) begin
                idle(($urandom_range(0, 1) == 0) ? T - 1 : T);
            end else if (op == 14) begin
                step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'($urandom), ($urandom_range(0, 1) == 0));
            end else begin
                step(($urandom_range(0, 4) == 0), 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);
            end
            check_all("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
